// File: rtl/mem_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_ctrl : LSB load/store and instruction-fetch responder on a byte-wide RAM
//            port, with sub-word sign/zero extension and I/O write stalling.
// Revision  : 1.0
// ----------------------------------------------------------------------------
module mem_ctrl #(
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_flag,
  input  logic        lsb_req,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_data,
  input  logic        lsb_is_store,
  input  logic [3:0]  lsb_op,
  output logic        lsb_ready,
  output logic [31:0] lsb_val,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] data_q, data_d;
  logic [31:0] buf_q, buf_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  n_q, n_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        src_if_q, src_if_d;
  logic        io_q, io_d;
  logic        kill_q, kill_d;
  logic        frz_q, frz_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        lsb_ready_q, lsb_ready_d;
  logic [31:0] lsb_val_q, lsb_val_d;
  logic        if_ready_q, if_ready_d;
  logic [31:0] if_data_q, if_data_d;

  logic [2:0]  w_cnt_inc;
  logic [1:0]  w_cap_idx;
  logic [2:0]  w_lsb_n;
  logic [31:0] w_word;
  logic [31:0] w_ext;
  logic        w_stall;
  logic        w_unused_op;

  assign w_unused_op = lsb_op[3];
  assign w_cnt_inc   = cnt_q + 3'd1;
  assign w_cap_idx   = cnt_q[1:0] - 2'd1;
  assign w_stall     = (state_q == S_WRITE) && io_q && io_buffer_full;

  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign mem_wr    = (state_q == S_WRITE) && !w_stall;
  assign lsb_ready = lsb_ready_q;
  assign lsb_val   = lsb_val_q;
  assign if_ready  = if_ready_q;
  assign if_data   = if_data_q;

  always_comb begin
    case (lsb_op[1:0])
      2'b00:   w_lsb_n = 3'd1;
      2'b01:   w_lsb_n = 3'd2;
      default: w_lsb_n = 3'd4;
    endcase
  end

  // Byte arriving this cycle belongs to the beat issued one cycle earlier.
  always_comb begin
    w_word = buf_q;
    w_word[{w_cap_idx, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    case (size_q)
      2'b00:   w_ext = uns_q ? {24'd0, w_word[7:0]}  : {{24{w_word[7]}},  w_word[7:0]};
      2'b01:   w_ext = uns_q ? {16'd0, w_word[15:0]} : {{16{w_word[15]}}, w_word[15:0]};
      default: w_ext = w_word;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    data_d      = data_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    size_d      = size_q;
    uns_d       = uns_q;
    src_if_d    = src_if_q;
    io_d        = io_q;
    kill_d      = kill_q;
    frz_d       = !rdy_in;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    lsb_ready_d = lsb_ready_q;
    lsb_val_d   = lsb_val_q;
    if_ready_d  = if_ready_q;
    if_data_d   = if_data_q;

    if (rdy_in) begin
      lsb_ready_d = 1'b0;
      if_ready_d  = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!clear_flag && lsb_req) begin
            base_d   = lsb_addr;
            data_d   = lsb_data;
            size_d   = lsb_op[1:0];
            uns_d    = lsb_op[2];
            n_d      = w_lsb_n;
            src_if_d = 1'b0;
            io_d     = (lsb_addr >= IO_BASE);
            kill_d   = 1'b0;
            cnt_d    = 3'd0;
            buf_d    = 32'd0;
            mem_a_d  = lsb_addr;
            if (lsb_is_store) begin
              mem_dout_d = lsb_data[7:0];
              state_d    = S_WRITE;
            end else begin
              state_d    = S_READ;
            end
          end else if (!clear_flag && if_req) begin
            base_d   = if_addr;
            size_d   = 2'b10;
            uns_d    = 1'b0;
            n_d      = 3'd4;
            src_if_d = 1'b1;
            io_d     = 1'b0;
            kill_d   = 1'b0;
            cnt_d    = 3'd0;
            buf_d    = 32'd0;
            mem_a_d  = if_addr;
            state_d  = S_READ;
          end
        end

        S_READ: begin
          if (clear_flag) begin
            state_d = S_IDLE;
          end else if (frz_q) begin
            // RAM data seen after a freeze is stale; restart the whole read.
            cnt_d   = 3'd0;
            mem_a_d = base_q;
          end else begin
            if (cnt_q != 3'd0) begin
              buf_d = w_word;
            end
            if (cnt_q == n_q) begin
              state_d = S_DONE;
              if (src_if_q) begin
                if_ready_d = 1'b1;
                if_data_d  = w_word;
              end else begin
                lsb_ready_d = 1'b1;
                lsb_val_d   = w_ext;
              end
            end else begin
              cnt_d = w_cnt_inc;
              if (w_cnt_inc < n_q) begin
                mem_a_d = base_q + {29'd0, w_cnt_inc};
              end
            end
          end
        end

        S_WRITE: begin
          if (clear_flag) begin
            kill_d = 1'b1;
          end
          if (!w_stall) begin
            if (cnt_q == n_q - 3'd1) begin
              if (clear_flag || kill_q) begin
                state_d = S_IDLE;
              end else begin
                state_d     = S_DONE;
                lsb_ready_d = 1'b1;
                lsb_val_d   = 32'd0;
              end
            end else begin
              cnt_d      = w_cnt_inc;
              mem_a_d    = base_q + {29'd0, w_cnt_inc};
              mem_dout_d = data_q[{w_cnt_inc[1:0], 3'b000} +: 8];
            end
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      base_q      <= 32'd0;
      data_q      <= 32'd0;
      buf_q       <= 32'd0;
      cnt_q       <= 3'd0;
      n_q         <= 3'd0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      src_if_q    <= 1'b0;
      io_q        <= 1'b0;
      kill_q      <= 1'b0;
      frz_q       <= 1'b0;
      mem_a_q     <= 32'd0;
      mem_dout_q  <= 8'd0;
      lsb_ready_q <= 1'b0;
      lsb_val_q   <= 32'd0;
      if_ready_q  <= 1'b0;
      if_data_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      data_q      <= data_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      src_if_q    <= src_if_d;
      io_q        <= io_d;
      kill_q      <= kill_d;
      frz_q       <= frz_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      lsb_ready_q <= lsb_ready_d;
      lsb_val_q   <= lsb_val_d;
      if_ready_q  <= if_ready_d;
      if_data_q   <= if_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_mem_ctrl : directed and randomized checks of mem_ctrl against a byte-map
//               reference model of memory contents and access timing.
// Revision    : 1.0
// ----------------------------------------------------------------------------
module tb_mem_ctrl;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_flag;
  logic        lsb_req, lsb_is_store, if_req, io_buffer_full;
  logic [31:0] lsb_addr, lsb_data, if_addr;
  logic [3:0]  lsb_op;
  logic        lsb_ready, if_ready, mem_wr;
  logic [31:0] lsb_val, if_data, mem_a;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;

  int vectors = 0;
  int errors  = 0;

  logic [7:0]  ram  [logic [31:0]];
  logic [7:0]  refm [logic [31:0]];
  logic [39:0] wq [$];

  always #5 clk_in = ~clk_in;

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_flag(clear_flag),
    .lsb_req(lsb_req), .lsb_addr(lsb_addr), .lsb_data(lsb_data),
    .lsb_is_store(lsb_is_store), .lsb_op(lsb_op), .lsb_ready(lsb_ready),
    .lsb_val(lsb_val), .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_data(if_data), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  function automatic logic [7:0] fill(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : fill(a);
  endfunction
  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : fill(a);
  endfunction
  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ram[a]  = b;
    refm[a] = b;
  endtask

  // Synchronous byte RAM: data for the address seen at an edge appears after it.
  always @(posedge clk_in) begin
    mem_din <= ram_rd(mem_a);
    if (mem_wr) begin
      ram[mem_a] = mem_dout;
      wq.push_back({mem_a, mem_dout});
    end
  end

  function automatic int nbytes(input logic [3:0] op);
    return (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [3:0] op);
    int     n;
    longint v;
    n = nbytes(op);
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_rd(a + 32'(i))) << (8 * i);
    if (n < 4 && !op[2] && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] op);
    for (int i = 0; i < nbytes(op); i++) refm[a + 32'(i)] = 8'((d >> (8 * i)) & 32'hFF);
  endtask

  // Drivers start and end on a falling edge; they only collect observations.
  task automatic run_lsb(input logic st, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] op, output logic [31:0] val, output int cyc,
                         output logic to, output logic post);
    lsb_req = 1'b1; lsb_is_store = st; lsb_addr = a; lsb_data = d; lsb_op = op;
    to = 1'b1; cyc = 0; val = 32'hx;
    for (int i = 1; i <= 60 && to; i++) begin
      @(negedge clk_in);
      if (lsb_ready) begin to = 1'b0; cyc = i; val = lsb_val; end
    end
    lsb_req = 1'b0;
    @(negedge clk_in);
    post = lsb_ready;
  endtask

  task automatic run_if(input logic [31:0] a, output logic [31:0] val, output int cyc,
                        output logic to, output logic post);
    if_req = 1'b1; if_addr = a;
    to = 1'b1; cyc = 0; val = 32'hx;
    for (int i = 1; i <= 60 && to; i++) begin
      @(negedge clk_in);
      if (if_ready) begin to = 1'b0; cyc = i; val = if_data; end
    end
    if_req = 1'b0;
    @(negedge clk_in);
    post = if_ready;
  endtask

  task automatic test_reset;
    rst_in = 1'b1; rdy_in = 1'b1; clear_flag = 1'b0; lsb_req = 1'b0; if_req = 1'b0;
    lsb_is_store = 1'b0; lsb_addr = '0; lsb_data = '0; lsb_op = '0; if_addr = '0;
    io_buffer_full = 1'b0;
    @(negedge clk_in);
    vectors++; if (mem_a !== 32'd0)     begin errors++; $display("FAIL reset mem_a got %h want 0", mem_a); end
    vectors++; if (mem_dout !== 8'd0)   begin errors++; $display("FAIL reset mem_dout got %h want 0", mem_dout); end
    vectors++; if (mem_wr !== 1'b0)     begin errors++; $display("FAIL reset mem_wr got %b want 0", mem_wr); end
    vectors++; if (lsb_ready !== 1'b0)  begin errors++; $display("FAIL reset lsb_ready got %b want 0", lsb_ready); end
    vectors++; if (lsb_val !== 32'd0)   begin errors++; $display("FAIL reset lsb_val got %h want 0", lsb_val); end
    vectors++; if (if_ready !== 1'b0)   begin errors++; $display("FAIL reset if_ready got %b want 0", if_ready); end
    vectors++; if (if_data !== 32'd0)   begin errors++; $display("FAIL reset if_data got %h want 0", if_data); end
    rst_in = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic test_loads;
    logic [31:0] a [4];
    logic [3:0]  op [4];
    logic [31:0] want [4];
    logic [31:0] v; int c; logic to, post;
    poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h84);
    poke(32'h200, 8'h80); poke(32'h210, 8'h34); poke(32'h211, 8'hF2);
    a[0] = 32'h100; op[0] = 4'b0010; want[0] = 32'h84332211;
    a[1] = 32'h200; op[1] = 4'b0000; want[1] = 32'hFFFFFF80;
    a[2] = 32'h200; op[2] = 4'b0100; want[2] = 32'h00000080;
    a[3] = 32'h210; op[3] = 4'b0001; want[3] = 32'hFFFFF234;
    for (int k = 0; k < 4; k++) begin
      run_lsb(1'b0, a[k], 32'h0, op[k], v, c, to, post);
      vectors++; if (to || v !== want[k]) begin errors++; $display("FAIL load%0d value got %h want %h (timeout=%b)", k, v, want[k], to); end
      vectors++; if (c != nbytes(op[k]) + 2) begin errors++; $display("FAIL load%0d latency got %0d want %0d", k, c, nbytes(op[k]) + 2); end
      vectors++; if (post !== 1'b0) begin errors++; $display("FAIL load%0d ready_width got %b want 0", k, post); end
    end
  endtask

  task automatic test_store;
    logic [31:0] v; int c; logic to, post;
    logic [39:0] exp_w;
    wq.delete();
    run_lsb(1'b1, 32'h300, 32'hDEADBEEF, 4'b0010, v, c, to, post);
    model_store(32'h300, 32'hDEADBEEF, 4'b0010);
    vectors++; if (to || v !== 32'd0) begin errors++; $display("FAIL sw value got %h want 0 (timeout=%b)", v, to); end
    vectors++; if (c != 5) begin errors++; $display("FAIL sw latency got %0d want 5", c); end
    vectors++; if (wq.size() != 4) begin errors++; $display("FAIL sw beats got %0d want 4", wq.size()); end
    for (int i = 0; i < 4 && i < wq.size(); i++) begin
      exp_w = {32'h300 + 32'(i), ref_rd(32'h300 + 32'(i))};
      vectors++; if (wq[i] !== exp_w) begin errors++; $display("FAIL sw beat%0d got %h want %h", i, wq[i], exp_w); end
    end
  endtask

  task automatic test_io_stall;
    int c; logic to;
    wq.delete();
    io_buffer_full = 1'b1;
    lsb_req = 1'b1; lsb_is_store = 1'b1; lsb_addr = 32'h0003_0000; lsb_data = 32'h1234_565A; lsb_op = 4'b0000;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk_in);
      vectors++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL io_stall cycle%0d mem_wr got %b want 0", i, mem_wr); end
    end
    @(negedge clk_in);
    io_buffer_full = 1'b0;
    #1;
    vectors++; if (mem_wr !== 1'b1 || mem_a !== 32'h0003_0000 || mem_dout !== 8'h5A) begin
      errors++; $display("FAIL io_release got wr=%b a=%h d=%h want 1 00030000 5a", mem_wr, mem_a, mem_dout); end
    to = 1'b1; c = 0;
    for (int i = 5; i <= 40 && to; i++) begin
      @(negedge clk_in);
      if (lsb_ready) begin to = 1'b0; c = i; end
    end
    lsb_req = 1'b0;
    vectors++; if (to || c != 5) begin errors++; $display("FAIL io_ready cycle got %0d want 5 (timeout=%b)", c, to); end
    vectors++; if (wq.size() != 1) begin errors++; $display("FAIL io_writes got %0d want 1", wq.size()); end
    model_store(32'h0003_0000, 32'h1234_565A, 4'b0000);
    @(negedge clk_in);
  endtask

  task automatic test_back_to_back;
    int lt, it; logic both; logic [31:0] lv, iv;
    lt = 0; it = 0; both = 1'b0; lv = 'x; iv = 'x;
    lsb_req = 1'b1; lsb_is_store = 1'b0; lsb_addr = 32'h100; lsb_op = 4'b0010;
    if_req = 1'b1; if_addr = 32'h600;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_in);
      if (lsb_ready && if_ready) both = 1'b1;
      if (lsb_ready && lt == 0) begin lt = c; lv = lsb_val; lsb_req = 1'b0; end
      if (if_ready && it == 0) begin it = c; iv = if_data; if_req = 1'b0; end
    end
    lsb_req = 1'b0; if_req = 1'b0;
    vectors++; if (lt != 6) begin errors++; $display("FAIL arb lsb_cycle got %0d want 6", lt); end
    vectors++; if (it != 13) begin errors++; $display("FAIL arb if_cycle got %0d want 13", it); end
    vectors++; if (lv !== model_load(32'h100, 4'b0010)) begin errors++; $display("FAIL arb lsb_val got %h want %h", lv, model_load(32'h100, 4'b0010)); end
    vectors++; if (iv !== model_load(32'h600, 4'b0010)) begin errors++; $display("FAIL arb if_data got %h want %h", iv, model_load(32'h600, 4'b0010)); end
    vectors++; if (both !== 1'b0) begin errors++; $display("FAIL arb overlap got %b want 0", both); end
  endtask

  task automatic test_clear_fetch;
    logic [31:0] v; int c; logic to, post;
    if_req = 1'b1; if_addr = 32'h700;
    @(negedge clk_in); @(negedge clk_in);
    clear_flag = 1'b1; if_req = 1'b0;
    @(negedge clk_in);
    clear_flag = 1'b0;
    run_if(32'h704, v, c, to, post);
    vectors++; if (to || c != 6) begin errors++; $display("FAIL clr_fetch next_latency got %0d want 6 (timeout=%b)", c, to); end
    vectors++; if (v !== model_load(32'h704, 4'b0010)) begin errors++; $display("FAIL clr_fetch next_data got %h want %h", v, model_load(32'h704, 4'b0010)); end
  endtask

  task automatic test_clear_store;
    logic seen; logic [31:0] d, v; int c; logic to, post;
    logic [39:0] exp_w;
    d = $urandom; seen = 1'b0;
    wq.delete();
    lsb_req = 1'b1; lsb_is_store = 1'b1; lsb_addr = 32'h400; lsb_data = d; lsb_op = 4'b0010;
    @(negedge clk_in); @(negedge clk_in);
    clear_flag = 1'b1; lsb_req = 1'b0;
    @(negedge clk_in);
    clear_flag = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (lsb_ready) seen = 1'b1;
      @(negedge clk_in);
    end
    model_store(32'h400, d, 4'b0010);
    vectors++; if (seen !== 1'b0) begin errors++; $display("FAIL clr_sw ready got %b want 0", seen); end
    vectors++; if (wq.size() != 4) begin errors++; $display("FAIL clr_sw beats got %0d want 4", wq.size()); end
    for (int i = 0; i < 4 && i < wq.size(); i++) begin
      exp_w = {32'h400 + 32'(i), ref_rd(32'h400 + 32'(i))};
      vectors++; if (wq[i] !== exp_w) begin errors++; $display("FAIL clr_sw beat%0d got %h want %h", i, wq[i], exp_w); end
    end
    run_lsb(1'b0, 32'h400, 32'h0, 4'b0010, v, c, to, post);
    vectors++; if (to || v !== d) begin errors++; $display("FAIL clr_sw readback got %h want %h", v, d); end
  endtask

  task automatic test_freeze;
    logic [31:0] v, a_hold; int c; logic to; logic held;
    for (int i = 0; i < 4; i++) poke(32'h500 + 32'(i), 8'($urandom));
    held = 1'b1; v = 'x; to = 1'b1; c = 0;
    lsb_req = 1'b1; lsb_is_store = 1'b0; lsb_addr = 32'h500; lsb_op = 4'b0010;
    @(negedge clk_in); @(negedge clk_in); @(negedge clk_in);
    rdy_in = 1'b0; a_hold = mem_a;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      if (mem_a !== a_hold || lsb_ready !== 1'b0) held = 1'b0;
    end
    rdy_in = 1'b1;
    for (int i = 1; i <= 40 && to; i++) begin
      @(negedge clk_in);
      if (lsb_ready) begin to = 1'b0; c = i; v = lsb_val; end
    end
    lsb_req = 1'b0;
    @(negedge clk_in);
    vectors++; if (held !== 1'b1) begin errors++; $display("FAIL freeze hold got %b want 1", held); end
    vectors++; if (to || v !== model_load(32'h500, 4'b0010)) begin errors++; $display("FAIL freeze value got %h want %h (timeout=%b)", v, model_load(32'h500, 4'b0010), to); end
  endtask

  task automatic test_random;
    logic [31:0] a, d, v, want; logic [3:0] op; int kind, c, n; logic to, post;
    logic [39:0] exp_w;
    for (int k = 0; k < 40; k++) begin
      a    = 32'h1000 + 32'($urandom_range(0, 63));
      d    = $urandom;
      kind = $urandom_range(0, 3);
      op   = {1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
      n    = nbytes(op);
      if (kind == 3) begin
        a = a & 32'hFFFF_FFFC;
        want = model_load(a, 4'b0010);
        run_if(a, v, c, to, post);
        vectors++; if (to || v !== want || c != 6 || post !== 1'b0) begin
          errors++; $display("FAIL rnd%0d fetch @%h got %h/%0d want %h/6", k, a, v, c, want); end
      end else if (kind == 2) begin
        wq.delete();
        run_lsb(1'b1, a, d, op, v, c, to, post);
        model_store(a, d, op);
        vectors++; if (to || v !== 32'd0 || c != n + 1 || wq.size() != n) begin
          errors++; $display("FAIL rnd%0d store @%h got val=%h cyc=%0d beats=%0d want 0/%0d/%0d", k, a, v, c, wq.size(), n + 1, n); end
        for (int i = 0; i < n && i < wq.size(); i++) begin
          exp_w = {a + 32'(i), ref_rd(a + 32'(i))};
          vectors++; if (wq[i] !== exp_w) begin errors++; $display("FAIL rnd%0d store_beat%0d got %h want %h", k, i, wq[i], exp_w); end
        end
      end else begin
        want = model_load(a, op);
        run_lsb(1'b0, a, 32'h0, op, v, c, to, post);
        vectors++; if (to || v !== want || c != n + 2 || post !== 1'b0) begin
          errors++; $display("FAIL rnd%0d load @%h op=%h got %h/%0d want %h/%0d", k, a, op, v, c, want, n + 2); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_store();
    test_io_stall();
    test_back_to_back();
    test_clear_fetch();
    test_clear_store();
    test_freeze();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
